// File: rtl/linked_list_pkg.sv
// Shared types and width helpers for the pooled multi-list linked-list manager.
package linked_list_pkg;

    typedef enum logic [2:0] {
        OP_READ_IDX     = 3'd0,
        OP_INSERT_IDX   = 3'd1,
        OP_DELETE_VALUE = 3'd2,
        OP_DELETE_IDX   = 3'd3,
        OP_PUSH_FRONT   = 3'd4,
        OP_PUSH_BACK    = 3'd5,
        OP_POP_FRONT    = 3'd6,
        OP_POP_BACK     = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WALK,
        ST_LINK,
        ST_DONE
    } state_e;

    function automatic int addr_width(input int max_node);
        return $clog2(max_node + 1);
    endfunction

    function automatic int list_width(input int num_lists);
        return (num_lists > 1) ? $clog2(num_lists) : 1;
    endfunction

    function automatic int addr_null(input int max_node);
        return max_node;
    endfunction

endpackage

// File: rtl/ll_free_stack.sv
// LIFO stack of free node addresses; after reset it hands out nodes 0,1,2,... in order.
module ll_free_stack
    import linked_list_pkg::*;
#(
    parameter int MAX_NODE   = 8,
    parameter int ADDR_WIDTH = addr_width(MAX_NODE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alloc,
    input  logic                  free,
    input  logic [ADDR_WIDTH-1:0] free_addr,
    output logic [ADDR_WIDTH-1:0] alloc_addr,
    output logic [ADDR_WIDTH-1:0] count
);

    localparam logic [ADDR_WIDTH-1:0] ONE_A  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] FULL_C = ADDR_WIDTH'(MAX_NODE);

    // One spare slot keeps the index width equal to ADDR_WIDTH; it is never read.
    logic [ADDR_WIDTH-1:0] stack [MAX_NODE+1];

    assign alloc_addr = stack[count - ONE_A];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= FULL_C;
            for (int i = 0; i <= MAX_NODE; i++) begin
                stack[i] <= (i < MAX_NODE) ? ADDR_WIDTH'(MAX_NODE - 1 - i) : FULL_C;
            end
        end else if (alloc && (count != '0)) begin
            count <= count - ONE_A;
        end else if (free && (count != FULL_C)) begin
            stack[count] <= free_addr;
            count        <= count + ONE_A;
        end
    end

endmodule

// File: rtl/multi_linked_list.sv
// NUM_LISTS doubly linked lists sharing one node pool, driven by a single op handshake.
module multi_linked_list
    import linked_list_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int MAX_NODE   = 8,
    parameter  int NUM_LISTS  = 2,
    localparam int ADDR_WIDTH = addr_width(MAX_NODE),
    localparam int LIST_WIDTH = list_width(NUM_LISTS)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            op_start,
    input  logic [2:0]                      op,
    input  logic [LIST_WIDTH-1:0]           list_sel,
    input  logic [ADDR_WIDTH-1:0]           addr_in,
    input  logic [DATA_WIDTH-1:0]           data_in,
    output logic                            op_ready,
    output logic                            op_done,
    output logic                            fault,
    output logic [DATA_WIDTH-1:0]           data_out,
    output logic [NUM_LISTS*ADDR_WIDTH-1:0] length,
    output logic [NUM_LISTS*ADDR_WIDTH-1:0] head,
    output logic [NUM_LISTS*ADDR_WIDTH-1:0] tail,
    output logic [NUM_LISTS-1:0]            empty,
    output logic                            full
);

    localparam logic [ADDR_WIDTH-1:0] NULL_A = ADDR_WIDTH'(addr_null(MAX_NODE));
    localparam logic [ADDR_WIDTH-1:0] ONE_A  = ADDR_WIDTH'(1);

    state_e                state, state_nx;
    op_e                   kind_q, kind_s, op_in;
    logic [LIST_WIDTH-1:0] sel_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [ADDR_WIDTH-1:0] ptr_q, cnt_q, len_s, head_s, tail_s, half_s, k_s, start_s;
    logic                  fwd_q, flt_q, fault_s, walk_s, from_head;

    // Node store carries one sentinel slot at ADDR_NULL so pointers index it directly.
    logic [DATA_WIDTH-1:0] data_mem [MAX_NODE+1];
    logic [ADDR_WIDTH-1:0] next_mem [MAX_NODE+1];
    logic [ADDR_WIDTH-1:0] prev_mem [MAX_NODE+1];
    logic [ADDR_WIDTH-1:0] head_r [NUM_LISTS];
    logic [ADDR_WIDTH-1:0] tail_r [NUM_LISTS];
    logic [ADDR_WIDTH-1:0] len_r  [NUM_LISTS];

    logic [ADDR_WIDTH-1:0] nxt_w, prv_w, head_q, tail_q, fs_addr, fs_count;
    logic                  hit_w, is_ins, is_del, fs_alloc, fs_free;

    assign nxt_w  = next_mem[ptr_q];
    assign prv_w  = prev_mem[ptr_q];
    assign hit_w  = (data_mem[ptr_q] == data_q);
    assign head_q = head_r[sel_q];
    assign tail_q = tail_r[sel_q];
    assign is_ins = (kind_q == OP_PUSH_FRONT) || (kind_q == OP_PUSH_BACK) || (kind_q == OP_INSERT_IDX);
    assign is_del = (kind_q == OP_POP_FRONT) || (kind_q == OP_POP_BACK) ||
                    (kind_q == OP_DELETE_IDX) || (kind_q == OP_DELETE_VALUE);
    assign fs_alloc = (state == ST_LINK) && is_ins;
    assign fs_free  = (state == ST_LINK) && is_del;
    assign full     = (fs_count == '0);
    assign op_ready = (state == ST_IDLE);

    ll_free_stack #(.MAX_NODE(MAX_NODE), .ADDR_WIDTH(ADDR_WIDTH)) u_free (
        .clk        (clk),
        .rst_n      (rst_n),
        .alloc      (fs_alloc),
        .free       (fs_free),
        .free_addr  (ptr_q),
        .alloc_addr (fs_addr),
        .count      (fs_count)
    );

    // Acceptance decode: fault screening, INSERT_IDX remapping, walk origin and distance.
    always_comb begin
        op_in     = op_e'(op);
        len_s     = len_r[list_sel];
        head_s    = head_r[list_sel];
        tail_s    = tail_r[list_sel];
        half_s    = (len_s - ONE_A) >> 1;
        from_head = (addr_in <= half_s);
        k_s       = from_head ? addr_in : (len_s - ONE_A - addr_in);
        start_s   = from_head ? head_s : tail_s;
        kind_s    = op_in;
        if (op_in == OP_INSERT_IDX) begin
            if (addr_in >= len_s)    kind_s = OP_PUSH_BACK;
            else if (addr_in == '0)  kind_s = OP_PUSH_FRONT;
        end
        case (op_in)
            OP_READ_IDX, OP_DELETE_IDX:               fault_s = (addr_in >= len_s);
            OP_INSERT_IDX, OP_PUSH_FRONT, OP_PUSH_BACK: fault_s = full;
            default:                                  fault_s = (len_s == '0);
        endcase
        fault_s = fault_s || (int'(list_sel) >= NUM_LISTS);
        if ((kind_s == OP_POP_FRONT) || (kind_s == OP_DELETE_VALUE)) start_s = head_s;
        if (kind_s == OP_POP_BACK)                                    start_s = tail_s;
        walk_s = (kind_s == OP_DELETE_VALUE) ||
                 (((kind_s == OP_READ_IDX) || (kind_s == OP_DELETE_IDX) ||
                   (kind_s == OP_INSERT_IDX)) && (k_s != '0));
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (op_start) state_nx = fault_s ? ST_DONE : (walk_s ? ST_WALK : ST_LINK);
            ST_WALK: begin
                if (kind_q == OP_DELETE_VALUE) begin
                    if (hit_w)                state_nx = ST_LINK;
                    else if (nxt_w == NULL_A) state_nx = ST_DONE;
                end else if (cnt_q == ONE_A) begin
                    state_nx = ST_LINK;
                end
            end
            ST_LINK: state_nx = ST_DONE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            kind_q   <= OP_READ_IDX;
            sel_q    <= '0;
            ptr_q    <= NULL_A;
            cnt_q    <= '0;
            fwd_q    <= 1'b1;
            flt_q    <= 1'b0;
            op_done  <= 1'b0;
            fault    <= 1'b0;
            data_out <= '0;
            for (int i = 0; i < NUM_LISTS; i++) begin
                head_r[i] <= NULL_A;
                tail_r[i] <= NULL_A;
                len_r[i]  <= '0;
            end
        end else begin
            state   <= state_nx;
            op_done <= (state == ST_DONE);
            fault   <= (state == ST_DONE) && flt_q;
            case (state)
                ST_IDLE: if (op_start) begin
                    kind_q <= kind_s;
                    sel_q  <= list_sel;
                    ptr_q  <= start_s;
                    cnt_q  <= k_s;
                    fwd_q  <= from_head;
                    flt_q  <= fault_s;
                end
                ST_WALK: begin
                    if (kind_q == OP_DELETE_VALUE) begin
                        if (!hit_w) begin
                            ptr_q <= nxt_w;
                            if (nxt_w == NULL_A) flt_q <= 1'b1;
                        end
                    end else begin
                        ptr_q <= fwd_q ? nxt_w : prv_w;
                        cnt_q <= cnt_q - ONE_A;
                    end
                end
                ST_LINK: begin
                    case (kind_q)
                        OP_READ_IDX: data_out <= data_mem[ptr_q];
                        OP_PUSH_FRONT: begin
                            head_r[sel_q] <= fs_addr;
                            if (head_q == NULL_A) tail_r[sel_q] <= fs_addr;
                            len_r[sel_q] <= len_r[sel_q] + ONE_A;
                        end
                        OP_PUSH_BACK: begin
                            tail_r[sel_q] <= fs_addr;
                            if (tail_q == NULL_A) head_r[sel_q] <= fs_addr;
                            len_r[sel_q] <= len_r[sel_q] + ONE_A;
                        end
                        OP_INSERT_IDX: len_r[sel_q] <= len_r[sel_q] + ONE_A;
                        default: begin
                            data_out <= data_mem[ptr_q];
                            if (prv_w == NULL_A) head_r[sel_q] <= nxt_w;
                            if (nxt_w == NULL_A) tail_r[sel_q] <= prv_w;
                            len_r[sel_q] <= len_r[sel_q] - ONE_A;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= MAX_NODE; i++) begin
                next_mem[i] <= NULL_A;
                prev_mem[i] <= NULL_A;
            end
        end else if (state == ST_LINK) begin
            case (kind_q)
                OP_READ_IDX: ;
                OP_PUSH_FRONT: begin
                    next_mem[fs_addr] <= head_q;
                    prev_mem[fs_addr] <= NULL_A;
                    if (head_q != NULL_A) prev_mem[head_q] <= fs_addr;
                end
                OP_PUSH_BACK: begin
                    prev_mem[fs_addr] <= tail_q;
                    next_mem[fs_addr] <= NULL_A;
                    if (tail_q != NULL_A) next_mem[tail_q] <= fs_addr;
                end
                OP_INSERT_IDX: begin
                    next_mem[fs_addr] <= ptr_q;
                    prev_mem[fs_addr] <= prv_w;
                    next_mem[prv_w]   <= fs_addr;
                    prev_mem[ptr_q]   <= fs_addr;
                end
                default: begin
                    if (prv_w != NULL_A) next_mem[prv_w] <= nxt_w;
                    if (nxt_w != NULL_A) prev_mem[nxt_w] <= prv_w;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if ((state == ST_IDLE) && op_start) data_q <= data_in;
        if ((state == ST_LINK) && is_ins)   data_mem[fs_addr] <= data_q;
    end

    always_comb begin
        for (int i = 0; i < NUM_LISTS; i++) begin
            length[i*ADDR_WIDTH +: ADDR_WIDTH] = len_r[i];
            head[i*ADDR_WIDTH +: ADDR_WIDTH]   = head_r[i];
            tail[i*ADDR_WIDTH +: ADDR_WIDTH]   = tail_r[i];
            empty[i]                           = (len_r[i] == '0);
        end
    end

endmodule

// File: tb/tb_multi_linked_list.sv
// Scoreboarded directed bench for multi_linked_list (8 nodes, 2 lists, plus a 3-list instance).
module tb_multi_linked_list;
    import linked_list_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       op_start = 1'b0;
    logic [2:0] op = '0;
    logic       list_sel = '0;
    logic [3:0] addr_in = '0;
    logic [7:0] data_in = '0;
    logic       op_ready, op_done, fault, full;
    logic [7:0] data_out, length, head, tail;
    logic [1:0] empty;

    logic        op_start3 = 1'b0;
    logic [2:0]  op3 = '0;
    logic [1:0]  list_sel3 = '0;
    logic [3:0]  addr_in3 = '0;
    logic [7:0]  data_in3 = '0;
    logic        op_ready3, op_done3, fault3, full3;
    logic [7:0]  data_out3;
    logic [11:0] length3, head3, tail3;
    logic [2:0]  empty3;

    always #5 clk = ~clk;

    multi_linked_list #(.DATA_WIDTH(8), .MAX_NODE(8), .NUM_LISTS(2)) dut (
        .clk(clk), .rst_n(rst_n), .op_start(op_start), .op(op), .list_sel(list_sel),
        .addr_in(addr_in), .data_in(data_in), .op_ready(op_ready), .op_done(op_done),
        .fault(fault), .data_out(data_out), .length(length), .head(head), .tail(tail),
        .empty(empty), .full(full)
    );

    multi_linked_list #(.DATA_WIDTH(8), .MAX_NODE(8), .NUM_LISTS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .op_start(op_start3), .op(op3), .list_sel(list_sel3),
        .addr_in(addr_in3), .data_in(data_in3), .op_ready(op_ready3), .op_done(op_done3),
        .fault(fault3), .data_out(data_out3), .length(length3), .head(head3), .tail(tail3),
        .empty(empty3), .full(full3)
    );

    typedef struct {
        string      name;
        logic       flt;
        logic [7:0] data;
        bit         chk;
        int         lat;
        int         e0;
    } exp_t;

    exp_t sb[$];
    exp_t got_e;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n && op_done) begin
            if (sb.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL unexpected_op_done: op_done=1 required 0 at cycle %0d", cyc);
            end else begin
                got_e = sb.pop_front();
                n_cmp++;
                if (fault !== got_e.flt) begin
                    n_fail++;
                    $display("FAIL %s fault: got %0b required %0b", got_e.name, fault, got_e.flt);
                end
                n_cmp++;
                if (cyc - got_e.e0 != got_e.lat) begin
                    n_fail++;
                    $display("FAIL %s latency: got %0d required %0d", got_e.name, cyc - got_e.e0, got_e.lat);
                end
                if (got_e.chk) begin
                    n_cmp++;
                    if (data_out !== got_e.data) begin
                        n_fail++;
                        $display("FAIL %s data_out: got 0x%0h required 0x%0h", got_e.name, data_out, got_e.data);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, got, req);
        end
    endtask

    task automatic issue(input string nm, input logic [2:0] o, input logic sel, input logic [3:0] a,
                         input logic [7:0] d, input logic ef, input logic [7:0] ed, input bit dchk,
                         input int lat);
        exp_t x;
        int   t;
        t = 0;
        @(negedge clk);
        while (!op_ready && t < 50) begin @(negedge clk); t++; end
        chk({nm, "_ready"}, op_ready, 1);
        op_start = 1'b1; op = o; list_sel = sel; addr_in = a; data_in = d;
        x.name = nm; x.flt = ef; x.data = ed; x.chk = dchk; x.lat = lat; x.e0 = cyc + 1;
        sb.push_back(x);
        @(negedge clk);
        chk({nm, "_busy"}, op_ready, 0);
        // Keep requesting with scrambled operands: must be ignored while busy.
        op = 3'($urandom); addr_in = 4'($urandom); data_in = 8'($urandom);
        @(negedge clk);
        op_start = 1'b0;
        t = 0;
        while (sb.size() != 0 && t < 60) begin @(negedge clk); t++; end
        if (sb.size() != 0) begin
            n_cmp++; n_fail++;
            $display("FAIL %s timeout: op_done never seen, required within 60 cycles", nm);
            sb.delete();
        end
    endtask

    task automatic check_reset(input string nm);
        chk({nm, "_head"}, head, 8'h88);
        chk({nm, "_tail"}, tail, 8'h88);
        chk({nm, "_length"}, length, 8'h00);
        chk({nm, "_empty"}, empty, 2'b11);
        chk({nm, "_full"}, full, 0);
        chk({nm, "_ready"}, op_ready, 1);
        chk({nm, "_done"}, op_done, 0);
        chk({nm, "_fault"}, fault, 0);
        chk({nm, "_data"}, data_out, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int e03;
        repeat (3) @(negedge clk);
        check_reset("rst");
        rst_n = 1'b1;
        @(negedge clk);

        issue("pb11", OP_PUSH_BACK, 0, 0, 8'h11, 0, 0, 0, 2);
        issue("pb22", OP_PUSH_BACK, 0, 0, 8'h22, 0, 0, 0, 2);
        issue("pb33", OP_PUSH_BACK, 0, 0, 8'h33, 0, 0, 0, 2);
        chk("l0_head", head, 8'h80);
        chk("l0_tail", tail, 8'h82);
        chk("l0_len", length, 8'h03);
        issue("rd2", OP_READ_IDX, 0, 2, 0, 0, 8'h33, 1, 2);
        issue("rd1", OP_READ_IDX, 0, 1, 0, 0, 8'h22, 1, 3);

        issue("pfAA", OP_PUSH_FRONT, 1, 0, 8'hAA, 0, 0, 0, 2);
        chk("l1_head", head, 8'h30);
        chk("l1_tail", tail, 8'h32);
        issue("popf0", OP_POP_FRONT, 0, 0, 0, 0, 8'h11, 1, 2);
        chk("popf_head", head, 8'h31);
        issue("pbBB", OP_PUSH_BACK, 1, 0, 8'hBB, 0, 0, 0, 2);
        chk("reuse_tail", tail, 8'h02);
        chk("reuse_len", length, 8'h22);
        issue("rdBB", OP_READ_IDX, 1, 1, 0, 0, 8'hBB, 1, 2);

        issue("pb44", OP_PUSH_BACK, 0, 0, 8'h44, 0, 0, 0, 2);
        issue("pbCC", OP_PUSH_BACK, 1, 0, 8'hCC, 0, 0, 0, 2);
        issue("pbDD", OP_PUSH_BACK, 1, 0, 8'hDD, 0, 0, 0, 2);
        issue("pbEE", OP_PUSH_BACK, 1, 0, 8'hEE, 0, 0, 0, 2);
        chk("fill_full", full, 1);
        chk("fill_len", length, 8'h53);
        chk("fill_tail", tail, 8'h74);
        issue("pb_full", OP_PUSH_BACK, 0, 0, 8'h55, 1, 8'hBB, 1, 1);
        chk("pb_full_len", length, 8'h53);

        issue("dv99", OP_DELETE_VALUE, 0, 0, 8'h99, 1, 8'hBB, 1, 4);
        issue("dv33", OP_DELETE_VALUE, 0, 0, 8'h33, 0, 8'h33, 1, 4);
        chk("dv_len", length, 8'h52);
        chk("dv_full", full, 0);
        issue("rd44", OP_READ_IDX, 0, 1, 0, 0, 8'h44, 1, 2);

        issue("ins77", OP_INSERT_IDX, 1, 3, 8'h77, 0, 0, 0, 3);
        chk("ins_len", length, 8'h62);
        issue("rd77", OP_READ_IDX, 1, 3, 0, 0, 8'h77, 1, 4);
        issue("rdDD", OP_READ_IDX, 1, 4, 0, 0, 8'hDD, 1, 3);
        issue("rdCC", OP_READ_IDX, 1, 2, 0, 0, 8'hCC, 1, 4);
        issue("diAA", OP_DELETE_IDX, 1, 0, 0, 0, 8'hAA, 1, 2);
        chk("di_head", head, 8'h01);
        issue("ins01", OP_INSERT_IDX, 0, 0, 8'h01, 0, 0, 0, 2);
        chk("ins0_head", head, 8'h03);
        issue("rd01", OP_READ_IDX, 0, 0, 0, 0, 8'h01, 1, 2);
        issue("di_oob", OP_DELETE_IDX, 0, 3, 0, 1, 8'h01, 1, 1);
        issue("ins_full", OP_INSERT_IDX, 0, 7, 8'h09, 1, 8'h01, 1, 1);

        issue("popb44", OP_POP_BACK, 0, 0, 0, 0, 8'h44, 1, 2);
        issue("popb22", OP_POP_BACK, 0, 0, 0, 0, 8'h22, 1, 2);
        issue("popf01", OP_POP_FRONT, 0, 0, 0, 0, 8'h01, 1, 2);
        chk("empty_l0", empty, 2'b01);
        issue("popb_empty", OP_POP_BACK, 0, 0, 0, 1, 8'h01, 1, 1);
        issue("dv_empty", OP_DELETE_VALUE, 0, 0, 8'h01, 1, 8'h01, 1, 1);
        issue("ins66", OP_INSERT_IDX, 0, 5, 8'h66, 0, 0, 0, 2);
        chk("ins66_head", head, 8'h03);
        chk("ins66_tail", tail, 8'h73);
        issue("rd66", OP_READ_IDX, 0, 0, 0, 0, 8'h66, 1, 2);

        // Third instance: list_sel beyond NUM_LISTS faults, in-range select works.
        @(negedge clk);
        op_start3 = 1'b1; op3 = OP_READ_IDX; list_sel3 = 2'd3; addr_in3 = '0;
        e03 = cyc + 1;
        @(negedge clk);
        op_start3 = 1'b0;
        t = 0;
        while (!op_done3 && t < 20) begin @(negedge clk); t++; end
        chk("sel3_latency", cyc - e03, 1);
        chk("sel3_fault", fault3, 1);
        @(negedge clk);
        op_start3 = 1'b1; op3 = OP_PUSH_BACK; list_sel3 = 2'd2; data_in3 = 8'h3C;
        e03 = cyc + 1;
        @(negedge clk);
        op_start3 = 1'b0;
        t = 0;
        while (!op_done3 && t < 20) begin @(negedge clk); t++; end
        chk("sel2_latency", cyc - e03, 2);
        chk("sel2_fault", fault3, 0);
        @(negedge clk);
        chk("sel2_length", length3, 12'h100);

        // Build a length-8 list, then reset during the index walk.
        issue("popf66", OP_POP_FRONT, 0, 0, 0, 0, 8'h66, 1, 2);
        issue("pb81", OP_PUSH_BACK, 1, 0, 8'h81, 0, 0, 0, 2);
        issue("pb82", OP_PUSH_BACK, 1, 0, 8'h82, 0, 0, 0, 2);
        issue("pb83", OP_PUSH_BACK, 1, 0, 8'h83, 0, 0, 0, 2);
        chk("len8", length, 8'h80);
        @(negedge clk);
        op_start = 1'b1; op = OP_DELETE_IDX; list_sel = 1; addr_in = 4'd3;
        @(negedge clk);
        op_start = 1'b0;
        chk("walk_busy", op_ready, 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_done", op_done, 0);
        @(negedge clk);
        check_reset("abort");
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_idle_ready", op_ready, 1);
        issue("pb5A", OP_PUSH_BACK, 0, 0, 8'h5A, 0, 0, 0, 2);
        chk("post_rst_head", head, 8'h80);
        issue("rd5A", OP_READ_IDX, 0, 0, 0, 0, 8'h5A, 1, 2);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
